mips_reg_writeback: RTL and testbench

- Writer side of the mips_registers write port; drives write_data, write_reg and signal_reg_write into the register file.
- Accepts two producers: single-cycle ALU results, and memory-load results delivered through a valid/ready handshake.
- Serialises both onto the single write port and buffers deferred load results in a small queue.
- Preserves register-write ordering and never writes register $0.

---
 rtl/mips_wb_pkg.sv | 26 ++
 rtl/mips_wb_fifo.sv | 91 +++++++++
 rtl/mips_reg_writeback.sv | 131 +++++++++++++
 tb/tb_mips_reg_writeback.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg
// Shared constants and types for the mips_registers write-back block.
//   WB_DATA_W / WB_ADDR_W / WB_QDEPTH : default widths and queue depth
//   REG_ZERO                          : the hard-wired zero register
//   wb_entry_t                        : load-queue entry {live, rd, data}
//   count_width()                     : occupancy counter width for a depth
package mips_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_QDEPTH = 4;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                 live;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Counter must hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mips_wb_fifo.sv
// mips_wb_fifo
// Circular queue of deferred load results. Each entry carries a live bit
// that can be cleared in place when a newer write to the same register
// makes the buffered value stale; dead entries still occupy a slot and are
// popped normally, the consumer just does not write them.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_reg/data   enqueue at tail (live=1)
//   pop                   drop head entry
//   kill_en, kill_reg     clear live on every entry whose reg matches
//   head_live/reg/data    current head entry
//   count, full, empty    occupancy
module mips_wb_fifo
    import mips_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_QDEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [ADDR_W-1:0]         push_reg,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    input  logic                      kill_en,
    input  logic [ADDR_W-1:0]         kill_reg,
    output logic                      head_live,
    output logic [ADDR_W-1:0]         head_reg,
    output logic [DATA_W-1:0]         head_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0]  live_q;
    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;

    // Kill is applied before the push so that an entry entering in the same
    // cycle as a matching kill stays live: that load completes later and is
    // therefore the newer value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (reg_q[i] == kill_reg)) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (push) begin
                live_q[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy and live bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[wr_ptr]  <= push_reg;
            data_q[wr_ptr] <= push_data;
        end
    end

    assign head_live = live_q[rd_ptr];
    assign head_reg  = reg_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign count     = cnt;
    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);

endmodule

// File: rtl/mips_reg_writeback.sv
// mips_reg_writeback
// Drives the single write port of mips_registers from two producers:
// single-cycle ALU results (always accepted, highest priority) and load
// results arriving over a valid/ready handshake, buffered in a small queue
// and drained whenever the ALU is not writing. Register $0 is never written.
// A buffered load whose register is overwritten by the ALU is killed so an
// older load can never clobber a newer ALU value.
// Optional feature macro: MIPS_WB_BYPASS_EN adds two combinational bypass
// read ports that forward the value being written this cycle.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   alu_valid, alu_reg, alu_data     ALU result (no backpressure)
//   mem_valid, mem_ready, mem_reg,
//   mem_data                         load result handshake
//   write_data, write_reg,
//   signal_reg_write                 registered register-file write port
//   qcount                           load queue occupancy
//   busy                             queue non-empty or write in progress
//   byp_reg_n / byp_hit_n /
//   byp_data_n (n=1,2)               bypass ports, MIPS_WB_BYPASS_EN only
module mips_reg_writeback
    import mips_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int QDEPTH = WB_QDEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [ADDR_W-1:0]         alu_reg,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [ADDR_W-1:0]         mem_reg,
    input  logic [DATA_W-1:0]         mem_data,
    output logic [DATA_W-1:0]         write_data,
    output logic [ADDR_W-1:0]         write_reg,
    output logic                      signal_reg_write,
    output logic [$clog2(QDEPTH):0]   qcount,
    output logic                      busy
`ifdef MIPS_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]         byp_reg_1,
    input  logic [ADDR_W-1:0]         byp_reg_2,
    output logic                      byp_hit_1,
    output logic                      byp_hit_2,
    output logic [DATA_W-1:0]         byp_data_1,
    output logic [DATA_W-1:0]         byp_data_2
`endif
);

    logic                    alu_sel;
    logic                    mem_accept;
    logic                    push;
    logic                    pop;
    logic                    head_live;
    logic [ADDR_W-1:0]       head_reg;
    logic [DATA_W-1:0]       head_data;
    logic [$clog2(QDEPTH):0] count;
    logic                    full;
    logic                    empty;

    // An ALU result targeting $0 is not a request at all, so it neither
    // writes nor blocks the queue from draining.
    assign alu_sel = alu_valid && (alu_reg != ADDR_W'(REG_ZERO));

    // Ready comes from the registered count only: a pop this cycle does not
    // make room until the next cycle, keeping ready free of output paths.
    assign mem_ready  = !full && rst_n;
    assign mem_accept = mem_valid && mem_ready;

    // Loads to $0 complete the handshake but are dropped.
    assign push = mem_accept && (mem_reg != ADDR_W'(REG_ZERO));
    assign pop  = !alu_sel && !empty;

    mips_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_reg  (mem_reg),
        .push_data (mem_data),
        .pop       (pop),
        .kill_en   (alu_sel),
        .kill_reg  (alu_reg),
        .head_live (head_live),
        .head_reg  (head_reg),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Address and data hold when idle; only the strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signal_reg_write <= 1'b0;
            write_reg        <= '0;
            write_data       <= '0;
        end else if (alu_sel) begin
            signal_reg_write <= 1'b1;
            write_reg        <= alu_reg;
            write_data       <= alu_data;
        end else if (pop && head_live) begin
            signal_reg_write <= 1'b1;
            write_reg        <= head_reg;
            write_data       <= head_data;
        end else begin
            signal_reg_write <= 1'b0;
        end
    end

    assign qcount = count;
    assign busy   = !empty || signal_reg_write;

`ifdef MIPS_WB_BYPASS_EN
    // Forwards the value the register file is absorbing this cycle, which a
    // same-cycle read of the array would otherwise miss.
    assign byp_hit_1  = signal_reg_write && (write_reg == byp_reg_1) &&
                        (byp_reg_1 != ADDR_W'(REG_ZERO));
    assign byp_hit_2  = signal_reg_write && (write_reg == byp_reg_2) &&
                        (byp_reg_2 != ADDR_W'(REG_ZERO));
    assign byp_data_1 = byp_hit_1 ? write_data : '0;
    assign byp_data_2 = byp_hit_2 ? write_data : '0;
`endif

endmodule

// File: tb/tb_mips_reg_writeback.sv
module tb_mips_reg_writeback;

    localparam int QD = 4;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        signal_reg_write;
    logic [2:0]  qcount;
    logic        busy;
`ifdef MIPS_WB_BYPASS_EN
    logic [4:0]  byp_reg_1;
    logic [4:0]  byp_reg_2;
    logic        byp_hit_1;
    logic        byp_hit_2;
    logic [31:0] byp_data_1;
    logic [31:0] byp_data_2;
`endif

    mips_reg_writeback #(.DATA_W(32), .ADDR_W(5), .QDEPTH(QD)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alu_valid        (alu_valid),
        .alu_reg          (alu_reg),
        .alu_data         (alu_data),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_reg          (mem_reg),
        .mem_data         (mem_data),
        .write_data       (write_data),
        .write_reg        (write_reg),
        .signal_reg_write (signal_reg_write),
        .qcount           (qcount),
        .busy             (busy)
`ifdef MIPS_WB_BYPASS_EN
        ,
        .byp_reg_1        (byp_reg_1),
        .byp_reg_2        (byp_reg_2),
        .byp_hit_1        (byp_hit_1),
        .byp_hit_2        (byp_hit_2),
        .byp_data_1       (byp_data_1),
        .byp_data_2       (byp_data_2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference model: pending loads as a plain queue in arrival order.
    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [31:0] rf_exp [32];
    logic [31:0] rf_dut [32];
    logic [4:0]  wlog[$];
    bit          last_acc;
    int          total;
    int          bad;

    function automatic logic [42:0] exp_vec();
        logic [2:0] qn;
        qn = 3'(mq.size());
        return {m_we, m_reg, m_data, qn, (mq.size() != 0) || m_we,
                rst_n && (mq.size() < QD)};
    endfunction

    function automatic logic [42:0] obs_vec();
        return {signal_reg_write, write_reg, write_data, qcount, busy, mem_ready};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mr, input logic [31:0] md);
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
        mem_valid = mv;
        mem_reg   = mr;
        mem_data  = md;
    endtask

    // Advance one clock: apply the write-port rules to the model using the
    // inputs presented this cycle, then let the DUT take the edge.
    task automatic tick();
        bit   alu_req;
        bit   acc;
        ent_t e;
        alu_req  = alu_valid && (alu_reg != 5'd0);
        acc      = mem_valid && rst_n && (mq.size() < QD);
        last_acc = acc;
        if (alu_req) begin
            m_we   = 1'b1;
            m_reg  = alu_reg;
            m_data = alu_data;
            foreach (mq[i]) if (mq[i].rd == alu_reg) mq[i].live = 1'b0;
        end else if (mq.size() > 0) begin
            e    = mq.pop_front();
            m_we = e.live;
            if (e.live) begin
                m_reg  = e.rd;
                m_data = e.data;
            end
        end else begin
            m_we = 1'b0;
        end
        if (acc && (mem_reg != 5'd0)) mq.push_back({1'b1, mem_reg, mem_data});
        if (m_we) rf_exp[m_reg] = m_data;
        @(posedge clk);
        #1;
        if (signal_reg_write) begin
            rf_dut[write_reg] = write_data;
            wlog.push_back(write_reg);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs_vec() !== 43'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", obs_vec());
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (mem_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", mem_ready);
        end
    endtask

    task automatic test_alu_write();
        drive(1, 5'd2, 32'hFFFF0000, 0, 0, 0);
        tick();
        total++;
        if (signal_reg_write !== 1'b1 || write_reg !== 5'd2 || write_data !== 32'hFFFF0000) begin
            bad++;
            $display("FAIL alu_write: got we=%b reg=%0d data=%h want we=1 reg=2 data=ffff0000",
                     signal_reg_write, write_reg, write_data);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL alu_idle_hold: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
        if (rf_dut[2] !== 32'hFFFF0000) begin
            bad++;
            $display("FAIL alu_rf_read: got %h want ffff0000", rf_dut[2]);
        end
    endtask

    task automatic test_priority_order();
        logic [4:0] want [4];
        want[0] = 5'd5; want[1] = 5'd5; want[2] = 5'd3; want[3] = 5'd4;
        wlog.delete();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       drive(0, 0, 0, 1, 5'd3, 32'h00000333);
                1:       drive(1, 5'd5, 32'h55550001, 1, 5'd4, 32'h00000444);
                2:       drive(1, 5'd5, 32'h55550002, 0, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0);
            endcase
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL priority_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        total++;
        if (wlog.size() != 4) begin
            bad++;
            $display("FAIL priority_write_count: got %0d want 4", wlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (wlog[i] !== want[i]) begin
                    bad++;
                    $display("FAIL priority_order%0d: got %0d want %0d", i, wlog[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_full_queue();
        int  ld;
        bit  saw_full;
        ld       = 0;
        saw_full = 0;
        for (int c = 0; c < 24; c++) begin
            drive(c < 8, 5'd9, 32'h90000000 + 32'(c),
                  ld < 5, 5'(10 + ld), 32'hA0 + 32'(ld));
            tick();
            if (last_acc) ld++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL full_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (qcount == 3'd4) begin
                saw_full = 1;
                total++;
                if (mem_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL full_ready: got %b want 0 at qcount=4", mem_ready);
                end
            end
            if (c >= 8 && ld == 5 && mq.size() == 0 && !m_we) break;
        end
        total++;
        if (!saw_full) begin
            bad++;
            $display("FAIL full_reached: qcount never reached 4");
        end
        total++;
        if (rf_dut[14] !== 32'hA4 || rf_dut[10] !== 32'hA0) begin
            bad++;
            $display("FAIL full_fifth_load: got r10=%h r14=%h want a0 a4", rf_dut[10], rf_dut[14]);
        end
    endtask

    task automatic test_waw_kill();
        for (int c = 0; c < 7; c++) begin
            case (c)
                0:       drive(1, 5'd8, 32'h88888888, 1, 5'd7, 32'h11111111);
                1:       drive(1, 5'd7, 32'h22222222, 0, 0, 0);
                4:       drive(1, 5'd6, 32'h00000066, 1, 5'd6, 32'h00000077);
                default: drive(0, 0, 0, 0, 0, 0);
            endcase
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL waw_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        total++;
        if (rf_dut[7] !== 32'h22222222) begin
            bad++;
            $display("FAIL waw_kill_r7: got %h want 22222222", rf_dut[7]);
        end
        total++;
        if (rf_dut[6] !== 32'h00000077) begin
            bad++;
            $display("FAIL waw_same_cycle_r6: got %h want 00000077", rf_dut[6]);
        end
    endtask

    task automatic test_zero_reg();
        drive(1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 32'hCAFEF00D);
        #1;
        total++;
        if (mem_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_handshake_ready: got %b want 1", mem_ready);
        end
        tick();
        total++;
        if (signal_reg_write !== 1'b0 || qcount !== 3'd0) begin
            bad++;
            $display("FAIL zero_suppress: got we=%b qcount=%0d want 0 0", signal_reg_write, qcount);
        end
        // ALU to $0 must not block a queued load from draining.
        drive(1, 5'd13, 32'h13131313, 1, 5'd12, 32'h12121212);
        tick();
        drive(1, 5'd0, 32'h0BAD0BAD, 0, 0, 0);
        tick();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL zero_alu_pops: got %h want %h", obs_vec(), exp_vec());
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        bit          pv;
        logic [4:0]  pr;
        logic [31:0] pd;
        int          errs;
        pv   = 0;
        pr   = 0;
        pd   = 0;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            if (!pv && $urandom_range(0, 2) != 0) begin
                pv = 1;
                pr = 5'($urandom_range(0, 7));
                pd = $urandom;
            end
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, pv, pr, pd);
            tick();
            if (last_acc) pv = 0;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                errs++;
                if (errs < 5)
                    $display("FAIL random_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (QD + 1) tick();
        for (int r = 0; r < 32; r++) begin
            total++;
            if (rf_dut[r] !== rf_exp[r]) begin
                bad++;
                $display("FAIL random_rf_r%0d: got %h want %h", r, rf_dut[r], rf_exp[r]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            drive(1, 5'd1, 32'h01010100 + 32'(c), 1, 5'(20 + c), 32'h20200000 + 32'(c));
            tick();
        end
        total++;
        if (qcount !== 3'd3) begin
            bad++;
            $display("FAIL reset_mid_fill: got qcount=%0d want 3", qcount);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== 43'd0) begin
            bad++;
            $display("FAIL reset_mid_async: got %h want 0", obs_vec());
        end
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (signal_reg_write !== 1'b0 || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_mid_after%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef MIPS_WB_BYPASS_EN
    task automatic test_bypass();
        byp_reg_1 = 5'd2;
        byp_reg_2 = 5'd3;
        drive(1, 5'd2, 32'h2B2B2B2B, 0, 0, 0);
        tick();
        total++;
        if (byp_hit_1 !== 1'b1 || byp_data_1 !== 32'h2B2B2B2B) begin
            bad++;
            $display("FAIL bypass_hit1: got hit=%b data=%h want 1 2b2b2b2b", byp_hit_1, byp_data_1);
        end
        total++;
        if (byp_hit_2 !== 1'b0 || byp_data_2 !== 32'h0) begin
            bad++;
            $display("FAIL bypass_miss2: got hit=%b data=%h want 0 0", byp_hit_2, byp_data_2);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (byp_hit_1 !== 1'b0 || byp_data_1 !== 32'h0) begin
            bad++;
            $display("FAIL bypass_idle: got hit=%b data=%h want 0 0", byp_hit_1, byp_data_1);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        for (int r = 0; r < 32; r++) begin
            rf_exp[r] = '0;
            rf_dut[r] = '0;
        end
`ifdef MIPS_WB_BYPASS_EN
        byp_reg_1 = '0;
        byp_reg_2 = '0;
`endif
        test_reset();
        test_alu_write();
        test_priority_order();
        test_full_queue();
        test_waw_kill();
        test_zero_reg();
        test_random();
        test_reset_mid();
`ifdef MIPS_WB_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
